// File: rtl/tl_pkg.sv
// Shared transaction-layer types and constants.
// Used by the VC output arbiter and its picker.
package tl_pkg;

   localparam logic [3:0] ST_INIT = 4'b0001;
   localparam logic [3:0] ST_IDLE = 4'b0010;
   localparam logic [3:0] ST_ACT0 = 4'b0100;
   localparam logic [3:0] ST_ACT1 = 4'b1000;

   localparam int NUM_VC = 4;
   localparam int VC_W   = 2;

   // class field occupies the top CLS_W bits of a word
   localparam int CLS_W = 2;

   function automatic int cls_msb(input int data_w);
      return data_w - 1;
   endfunction

   function automatic int cls_lsb(input int data_w);
      return data_w - CLS_W;
   endfunction

   typedef enum logic {
      ARB  = 1'b0,
      XFER = 1'b1
   } arb_state_e;

   function automatic logic is_active(input logic [3:0] st);
      return (st == ST_ACT0) || (st == ST_ACT1);
   endfunction

   function automatic logic is_init(input logic [3:0] st);
      return st == ST_INIT;
   endfunction

endpackage

// File: rtl/vc_out_arbiter_if.sv
// VC FIFO drain / output FIFO fill signal bundle.
// master = arbiter side, slave = FIFO side.
interface vc_out_arbiter_if #(
   parameter int DATA_W = 12
);

   logic              empty_0;
   logic              empty_1;
   logic              empty_2;
   logic              empty_3;
   logic [DATA_W-1:0] data_in_0;
   logic [DATA_W-1:0] data_in_1;
   logic [DATA_W-1:0] data_in_2;
   logic [DATA_W-1:0] data_in_3;
   logic              almost_full_out;

   logic              pop_0;
   logic              pop_1;
   logic              pop_2;
   logic              pop_3;
   logic              push_out;
   logic [DATA_W-1:0] data_out;
   logic [1:0]        grant;

   modport master (
      input  empty_0, empty_1,
      input  empty_2, empty_3,
      input  data_in_0, data_in_1,
      input  data_in_2, data_in_3,
      input  almost_full_out,
      output pop_0, pop_1,
      output pop_2, pop_3,
      output push_out,
      output data_out,
      output grant
   );

   modport slave (
      output empty_0, empty_1,
      output empty_2, empty_3,
      output data_in_0, data_in_1,
      output data_in_2, data_in_3,
      output almost_full_out,
      input  pop_0, pop_1,
      input  pop_2, pop_3,
      input  push_out,
      input  data_out,
      input  grant
   );

endinterface

// File: rtl/vc_out_arbiter_rr_pick4.sv
// Four-way requester picker: round-robin from ptr, or
// fixed highest-index priority with VC_STRICT_PRIO_EN.
module rr_pick4
   import tl_pkg::*;
(
   input  logic [NUM_VC-1:0] req,
   input  logic [VC_W-1:0]   ptr,
   output logic [VC_W-1:0]   idx,
   output logic              valid
);

   logic [NUM_VC-1:0] vec;
   logic [NUM_VC-1:0] first;
   logic [VC_W-1:0]   off;

   assign valid = |req;

   // lowest set bit of the scan vector
   assign first = vec & (~vec + 4'd1);

   always_comb begin
      off = '0;
      unique case (1'b1)
         first[0]: off = 2'd0;
         first[1]: off = 2'd1;
         first[2]: off = 2'd2;
         first[3]: off = 2'd3;
         default:  off = 2'd0;
      endcase
   end

`ifdef VC_STRICT_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // reversed so VC3 lands on bit 0
   assign vec = {req[0], req[1],
                 req[2], req[3]};
   assign idx = 2'd3 - off;
`else
   always_comb begin
      vec = req;
      unique case (ptr)
         2'd0: vec = req;
         2'd1: vec = {req[0], req[3:1]};
         2'd2: vec = {req[1:0], req[3:2]};
         2'd3: vec = {req[2:0], req[3]};
         default: vec = req;
      endcase
   end

   assign idx = ptr + off;
`endif

endmodule

// File: rtl/vc_out_arbiter.sv
// Drains four VC FIFOs into the output FIFO, one word per 2 cycles.
// VC_STRICT_PRIO_EN selects fixed priority instead of round-robin.
module vc_out_arbiter
   import tl_pkg::*;
#(
   parameter int              DATA_W  = 12,
   parameter logic [VC_W-1:0] RR_INIT = '0
) (
   input logic              clk,
   input logic              reset_L,
   input logic [3:0]        state,
   vc_out_arbiter_if.master bus
);

   arb_state_e        fsm_q;
   arb_state_e        fsm_d;
   logic [VC_W-1:0]   ptr_q;
   logic [VC_W-1:0]   ptr_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;
   logic [VC_W-1:0]   grant_q;
   logic [VC_W-1:0]   grant_d;

   logic [NUM_VC-1:0] req;
   logic [NUM_VC-1:0] pop_vec;
   logic              push;
   logic [VC_W-1:0]   pick_idx;
   logic              pick_vld;
   logic              init;
   logic              can_arb;
   logic [DATA_W-1:0] head [NUM_VC];

   assign req = ~{bus.empty_3, bus.empty_2,
                  bus.empty_1, bus.empty_0};

   assign head[0] = bus.data_in_0;
   assign head[1] = bus.data_in_1;
   assign head[2] = bus.data_in_2;
   assign head[3] = bus.data_in_3;

   rr_pick4 u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   assign init = is_init(state);

   // reset_L gates the combinational pop path too
   assign can_arb = reset_L
                  & is_active(state)
                  & ~bus.almost_full_out
                  & pick_vld;

   always_comb begin
      fsm_d   = fsm_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      grant_d = grant_q;
      pop_vec = '0;
      push    = 1'b0;
      if (init) begin
         fsm_d   = ARB;
         ptr_d   = RR_INIT;
         data_d  = '0;
         grant_d = '0;
      end else begin
         unique case (fsm_q)
            ARB: begin
               if (can_arb) begin
                  pop_vec[pick_idx] = 1'b1;
                  data_d  = head[pick_idx];
                  grant_d = pick_idx;
`ifndef VC_STRICT_PRIO_EN
                  ptr_d   = pick_idx + 2'd1;
`endif
                  fsm_d   = XFER;
               end
            end
            XFER: begin
               // completes regardless of state/back-pressure
               push  = 1'b1;
               fsm_d = ARB;
            end
            default: fsm_d = ARB;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         fsm_q   <= ARB;
         ptr_q   <= RR_INIT;
         data_q  <= '0;
         grant_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         grant_q <= grant_d;
      end
   end

   assign bus.pop_0    = pop_vec[0];
   assign bus.pop_1    = pop_vec[1];
   assign bus.pop_2    = pop_vec[2];
   assign bus.pop_3    = pop_vec[3];
   assign bus.push_out = push;
   assign bus.data_out = data_q;
   assign bus.grant    = grant_q;

   a_pop_onehot : assert property (
      @(posedge clk) disable iff (!reset_L)
      $onehot0(pop_vec)
   );

   a_no_pop_push : assert property (
      @(posedge clk) disable iff (!reset_L)
      !(|pop_vec && push)
   );

endmodule

// File: tb/tb_vc_out_arbiter.sv
// Directed table-driven bench for vc_out_arbiter
// (round-robin build).
module tb_vc_out_arbiter;

   localparam logic [3:0] INI  = 4'b0001;
   localparam logic [3:0] IDL  = 4'b0010;
   localparam logic [3:0] ACT  = 4'b0100;
   localparam logic [3:0] ACT1 = 4'b1000;
   localparam logic [3:0] ZZ   = 4'b0000;

   typedef struct {
      logic [3:0]  st;
      logic [3:0]  emp;
      logic        af;
      logic [3:0]  pop;
      logic        push;
      logic [11:0] dat;
      logic [1:0]  gnt;
   } vec_t;

   logic       clk;
   logic       reset_L;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   vec_t tbl[$];

   vc_out_arbiter_if #(.DATA_W(12)) bus ();

   vc_out_arbiter #(
      .DATA_W  (12),
      .RR_INIT (2'd0)
   ) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .state   (state),
      .bus     (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] pops();
      return {bus.pop_3, bus.pop_2,
              bus.pop_1, bus.pop_0};
   endfunction

   task automatic chk(input string nm, input int i,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %h want %h",
                  nm, i, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] st,
                        input logic [3:0] emp,
                        input logic af);
      state               = st;
      bus.empty_0         = emp[0];
      bus.empty_1         = emp[1];
      bus.empty_2         = emp[2];
      bus.empty_3         = emp[3];
      bus.almost_full_out = af;
   endtask

   task automatic heads(input logic [11:0] d0,
                        input logic [11:0] d1,
                        input logic [11:0] d2,
                        input logic [11:0] d3);
      bus.data_in_0 = d0;
      bus.data_in_1 = d1;
      bus.data_in_2 = d2;
      bus.data_in_3 = d3;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_L = 1'b0;
      drive(IDL, 4'b1111, 1'b0);
      @(posedge clk);
      #1;
      reset_L = 1'b1;
   endtask

   task automatic add(input logic [3:0] st,
                      input logic [3:0] emp,
                      input logic af,
                      input logic [3:0] pop,
                      input logic push,
                      input logic [11:0] dat,
                      input logic [1:0] gnt);
      vec_t v;
      v.st   = st;
      v.emp  = emp;
      v.af   = af;
      v.pop  = pop;
      v.push = push;
      v.dat  = dat;
      v.gnt  = gnt;
      tbl.push_back(v);
   endtask

   task automatic chk_all(input string nm, input int i,
                          input logic [3:0] pop,
                          input logic push,
                          input logic [11:0] dat,
                          input logic [1:0] gnt);
      chk({nm, "_pop"}, i, 32'(pops()), 32'(pop));
      chk({nm, "_push"}, i, 32'(bus.push_out), 32'(push));
      chk({nm, "_data"}, i, 32'(bus.data_out), 32'(dat));
      chk({nm, "_grant"}, i, 32'(bus.grant), 32'(gnt));
   endtask

   initial begin
      // st    emp      af  pop      push dat      gnt
      add(ACT,  4'b0000, 0, 4'b0001, 0, 12'h000, 2'd0);
      add(ACT,  4'b0000, 0, 4'b0000, 1, 12'h001, 2'd0);
      add(ACT,  4'b0000, 0, 4'b0010, 0, 12'h001, 2'd0);
      add(ACT,  4'b0000, 0, 4'b0000, 1, 12'h402, 2'd1);
      add(ACT,  4'b0000, 0, 4'b0100, 0, 12'h402, 2'd1);
      add(ACT,  4'b0000, 0, 4'b0000, 1, 12'h803, 2'd2);
      add(ACT,  4'b0000, 0, 4'b1000, 0, 12'h803, 2'd2);
      add(ACT,  4'b0000, 0, 4'b0000, 1, 12'hC04, 2'd3);
      add(ACT,  4'b0000, 0, 4'b0001, 0, 12'hC04, 2'd3);
      add(ACT,  4'b0000, 1, 4'b0000, 1, 12'h001, 2'd0);
      add(ACT,  4'b0000, 1, 4'b0000, 0, 12'h001, 2'd0);
      add(ACT,  4'b0000, 1, 4'b0000, 0, 12'h001, 2'd0);
      add(ACT,  4'b0000, 0, 4'b0010, 0, 12'h001, 2'd0);
      add(IDL,  4'b0000, 0, 4'b0000, 1, 12'h402, 2'd1);
      add(IDL,  4'b0000, 0, 4'b0000, 0, 12'h402, 2'd1);
      add(ZZ,   4'b0000, 0, 4'b0000, 0, 12'h402, 2'd1);
      add(ACT1, 4'b0000, 0, 4'b0100, 0, 12'h402, 2'd1);
      add(ACT,  4'b0000, 0, 4'b0000, 1, 12'h803, 2'd2);
      add(ACT,  4'b1011, 0, 4'b0100, 0, 12'h803, 2'd2);
      add(ACT,  4'b1011, 0, 4'b0000, 1, 12'h803, 2'd2);
      add(ACT,  4'b1011, 0, 4'b0100, 0, 12'h803, 2'd2);
      add(ACT,  4'b1011, 0, 4'b0000, 1, 12'h803, 2'd2);
      add(ACT,  4'b1111, 0, 4'b0000, 0, 12'h803, 2'd2);
      add(ACT,  4'b1001, 0, 4'b0010, 0, 12'h803, 2'd2);
      add(ACT,  4'b1001, 0, 4'b0000, 1, 12'h402, 2'd1);
      add(ACT,  4'b1001, 0, 4'b0100, 0, 12'h402, 2'd1);
      add(ACT,  4'b1001, 0, 4'b0000, 1, 12'h803, 2'd2);
      add(INI,  4'b0000, 0, 4'b0000, 0, 12'h803, 2'd2);
      add(INI,  4'b0000, 0, 4'b0000, 0, 12'h000, 2'd0);
      add(ACT,  4'b0000, 0, 4'b0001, 0, 12'h000, 2'd0);
      add(ACT,  4'b0000, 0, 4'b0000, 1, 12'h001, 2'd0);

      // reset state, with active requesters held off
      reset_L = 1'b0;
      heads(12'h001, 12'h402, 12'h803, 12'hC04);
      drive(ACT, 4'b0000, 1'b0);
      #7;
      chk_all("rst", 0, 4'b0000, 1'b0, 12'h000, 2'd0);
      do_reset();
      @(negedge clk);
      chk_all("rst", 1, 4'b0000, 1'b0, 12'h000, 2'd0);

      // single requester VC2, repeating every 2 cycles
      do_reset();
      heads(12'h111, 12'h222, 12'h8A5, 12'h333);
      drive(ACT, 4'b1011, 1'b0);
      @(negedge clk);
      chk("one_pop", 0, 32'(pops()), 32'h4);
      chk("one_push", 0, 32'(bus.push_out), 32'h0);
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         chk_all("one_x", r, 4'b0000, 1'b1, 12'h8A5, 2'd2);
         @(negedge clk);
         chk("one_pop", r + 1, 32'(pops()), 32'h4);
         chk("one_push", r + 1, 32'(bus.push_out), 32'h0);
      end

      // main vector table
      do_reset();
      heads(12'h001, 12'h402, 12'h803, 12'hC04);
      foreach (tbl[i]) begin
         @(posedge clk);
         #1;
         drive(tbl[i].st, tbl[i].emp, tbl[i].af);
         @(negedge clk);
         chk_all("tbl", i, tbl[i].pop, tbl[i].push,
                 tbl[i].dat, tbl[i].gnt);
      end

      // async reset during XFER, then restart at RR_INIT
      do_reset();
      heads(12'h001, 12'h402, 12'h803, 12'hC04);
      drive(ACT, 4'b0000, 1'b0);
      @(negedge clk);
      chk("mid_pop", 0, 32'(pops()), 32'h1);
      @(posedge clk);
      #1;
      chk("mid_push", 0, 32'(bus.push_out), 32'h1);
      chk("mid_data", 0, 32'(bus.data_out), 32'h001);
      reset_L = 1'b0;
      #1;
      chk_all("mid_rst", 0, 4'b0000, 1'b0, 12'h000, 2'd0);
      @(posedge clk);
      #1;
      reset_L = 1'b1;
      @(negedge clk);
      chk_all("mid_rel", 0, 4'b0001, 1'b0, 12'h000, 2'd0);
      @(negedge clk);
      chk_all("mid_rel", 1, 4'b0000, 1'b1, 12'h001, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
